// File: rtl/gg_deblock_pkg.sv
// Shared deblocking definitions: colour-component codes, writeback entry type,
// output-stage states and the h264 block-index to 4x4 position mapping.
package gg_deblock_pkg;

  localparam logic [2:0] CIDX_LUMA = 3'd0;
  localparam logic [2:0] CIDX_CB   = 3'd2;
  localparam logic [2:0] CIDX_CR   = 3'd3;

  localparam int BLK_W     = 128;
  localparam int WB_ADDR_W = 22;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [BLK_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

  // h264 zig-zag of 8x8 quadrants: even bits select column, odd bits select row
  function automatic logic [1:0] bidx_bx(input logic [3:0] bidx);
    return {bidx[2], bidx[0]};
  endfunction

  function automatic logic [1:0] bidx_by(input logic [3:0] bidx);
    return {bidx[3], bidx[1]};
  endfunction

endpackage

// File: rtl/gg_wb_fifo_4w1r.sv
// Circular block queue: up to four compacted writes and one read per cycle,
// pointers carry an extra wrap bit so full and empty are distinguishable.
module gg_wb_fifo_4w1r #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 150
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           wr_cnt,
  input  logic [3:0][WIDTH-1:0] wr_lane,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 empty
);
  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      rd_ptr <= rd_ptr + PTR_W'(rd_en);
    end
  end

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i < int'(wr_cnt)) begin
        mem[wr_ptr[PW-1:0] + PW'(i)] <= wr_lane[i];
      end
    end
  end

  assign rd_data = mem[rd_ptr[PW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/gg_deblock_writeback.sv
// Deblocker writeback: turns the four finalized blocks per cycle into frame-store
// addresses, queues them and drains one 4x4 block per cycle over valid/ready.
module gg_deblock_writeback
  import gg_deblock_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 22,
  parameter logic [ADDR_W-1:0] LUMA_BASE = '0,
  parameter logic [ADDR_W-1:0] CB_BASE   = ADDR_W'(22'h10000),
  parameter logic [ADDR_W-1:0] CR_BASE   = ADDR_W'(22'h18000)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 mb_width,
  input  logic [7:0]                 mbx,
  input  logic [7:0]                 mby,
  input  logic                       valid,
  input  logic [2:0]                 cidx,
  input  logic [3:0]                 bidx,
  input  logic                       ale_valid,
  input  logic                       abv_valid,
  input  logic                       lef_valid,
  input  logic                       cur_valid,
  input  logic [BLK_W-1:0]           ale_filt,
  input  logic [BLK_W-1:0]           abv_filt,
  input  logic [BLK_W-1:0]           lef_filt,
  input  logic [BLK_W-1:0]           cur_filt,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [BLK_W-1:0]           wr_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       coord_err
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + BLK_W;

  logic [3:0]              lane_flag;
  logic [3:0][BLK_W-1:0]   lane_data;
  logic                    is_chroma;
  logic [ADDR_W-1:0]       plane_base;
  logic [ADDR_W-1:0]       stride;
  logic [11:0]             x0, y0;
  logic [3:0][11:0]        lane_x, lane_y;
  logic [3:0]              lane_req, lane_err;
  logic [3:0][EW-1:0]      lane_ent;

  logic [LW-1:0]           free_slots;
  logic [2:0]              n_acc;
  logic                    drop;
  logic [3:0][EW-1:0]      comp;

  out_state_e              out_state;
  logic                    consume, load, from_mem, bypass;
  logic [2:0]              fifo_cnt;
  logic [3:0][EW-1:0]      fifo_lane;
  logic [EW-1:0]           fifo_head;
  logic                    fifo_empty;

  // Lane order ale, abv, lef, cur is also the push order.
  assign lane_flag = {cur_valid, lef_valid, abv_valid, ale_valid};
  assign lane_data = {cur_filt, lef_filt, abv_filt, ale_filt};

  // ---- capture stage: per-lane position, address and validity ----
  always_comb begin
    is_chroma  = (cidx == CIDX_CB) || (cidx == CIDX_CR);
    plane_base = (cidx == CIDX_CB) ? CB_BASE :
                 (cidx == CIDX_CR) ? CR_BASE : LUMA_BASE;
    if (is_chroma) begin
      x0     = {3'b0, mbx, bidx[0]};
      y0     = {3'b0, mby, bidx[1]};
      stride = ADDR_W'({1'b0, mb_width} + 9'd1) << 1;
    end else begin
      x0     = {2'b0, mbx, 2'b0} + {10'b0, bidx_bx(bidx)};
      y0     = {2'b0, mby, 2'b0} + {10'b0, bidx_by(bidx)};
      stride = ADDR_W'({1'b0, mb_width} + 9'd1) << 2;
    end
    // Positions never exceed 1023, so bit 11 flags a step off the frame edge.
    for (int i = 0; i < 4; i++) begin
      lane_x[i]   = x0 - 12'((i == 0 || i == 2) ? 1 : 0);
      lane_y[i]   = y0 - 12'((i < 2) ? 1 : 0);
      lane_req[i] = valid & lane_flag[i] & ~(lane_x[i][11] | lane_y[i][11]);
      lane_err[i] = valid & lane_flag[i] &  (lane_x[i][11] | lane_y[i][11]);
      lane_ent[i] = {plane_base + ADDR_W'(lane_y[i]) * stride + ADDR_W'(lane_x[i]),
                     lane_data[i]};
    end
  end

  // Space is judged on the registered level; a pop this cycle is not credited.
  always_comb begin
    free_slots = LW'(DEPTH) - fifo_level;
    n_acc      = '0;
    drop       = 1'b0;
    comp       = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_req[i]) begin
        if (LW'(n_acc) < free_slots) begin
          comp[n_acc[1:0]] = lane_ent[i];
          n_acc            = n_acc + 3'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // The output register is the queue head; refill it from memory, or straight
  // from lane 0 when memory is empty, so a fresh block shows up one cycle later.
  always_comb begin
    consume  = (out_state == OUT_HOLD) && wr_ready;
    load     = (out_state == OUT_EMPTY) || consume;
    from_mem = load && !fifo_empty;
    bypass   = load && fifo_empty && (n_acc != 3'd0);
    if (bypass) begin
      fifo_lane = {EW'(0), comp[3], comp[2], comp[1]};
      fifo_cnt  = n_acc - 3'd1;
    end else begin
      fifo_lane = comp;
      fifo_cnt  = n_acc;
    end
  end

  gg_wb_fifo_4w1r #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_cnt  (fifo_cnt),
    .wr_lane (fifo_lane),
    .rd_en   (from_mem),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );

  // ---- output stage: EMPTY/HOLD skid register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state  <= OUT_EMPTY;
      wr_addr    <= '0;
      wr_data    <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      coord_err  <= 1'b0;
    end else begin
      fifo_level <= fifo_level + LW'(n_acc) - LW'(consume);
      overflow   <= overflow | drop;
      coord_err  <= coord_err | (|lane_err);
      if (load) begin
        if (from_mem) begin
          {wr_addr, wr_data} <= fifo_head;
          out_state          <= OUT_HOLD;
        end else if (bypass) begin
          {wr_addr, wr_data} <= comp[0];
          out_state          <= OUT_HOLD;
        end else begin
          out_state          <= OUT_EMPTY;
        end
      end
    end
  end

  assign wr_valid = (out_state == OUT_HOLD);

endmodule
